// File: rtl/sim_finish_pkg.sv
// Shared types and constants for the simulation finish controller.
package sim_finish_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    REQ   = 2'd2,
    DONE  = 2'd3
  } finish_state_t;

  localparam int unsigned CODE_W_DEF       = 8;
  localparam int unsigned DRAIN_CYCLES_DEF = 16;

  localparam logic [CODE_W_DEF-1:0] TIMEOUT_CODE = '1;

endpackage

// File: rtl/sat_counter.sv
// Free-running up-counter with synchronous clear; sticks at all-ones.
//   clk   : clock
//   clr   : synchronous clear to zero
//   count : current value
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (count_q != '1) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/sim_finish_ctrl.sv
// Finish-request source for the simulation top: accepts a completion, waits
// for traffic to drain, then holds finish_req until acknowledged. A cycle
// watchdog forces a timeout finish.
//   CLK/RST                  : clock, synchronous active-high reset
//   done_valid/code/ready    : completion handshake
//   busy_in                  : outstanding traffic, restarts the drain window
//   finish_req/finish_ack    : held request to the top and its acknowledge
//   exit_code/exit_timeout   : result reported with the request
//   cycle_count              : cycles since reset release (saturating)
module sim_finish_ctrl
  import sim_finish_pkg::*;
#(
  parameter int unsigned COUNT_W      = 32,
  parameter int unsigned CODE_W       = CODE_W_DEF,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int unsigned CYCLE_LIMIT  = 0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               done_valid,
  input  logic [CODE_W-1:0]  done_code,
  output logic               done_ready,
  input  logic               busy_in,
  output logic               finish_req,
  input  logic               finish_ack,
  output logic [CODE_W-1:0]  exit_code,
  output logic               exit_timeout,
  output logic [COUNT_W-1:0] cycle_count
);

  localparam int unsigned DRAIN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_RELOAD = DRAIN_W'(DRAIN_CYCLES);
  localparam bit WD_EN = (CYCLE_LIMIT != 0);
  localparam logic [COUNT_W-1:0] LIMIT_M1 = WD_EN ? COUNT_W'(CYCLE_LIMIT - 1) : '0;
  // Package constant is sized for the default width; wider codes still get all-ones.
  localparam logic [CODE_W-1:0] TO_CODE =
    (CODE_W == CODE_W_DEF) ? CODE_W'(TIMEOUT_CODE) : '1;

  finish_state_t      state_q, state_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [CODE_W-1:0]  exit_code_q, exit_code_d;
  logic               exit_timeout_q, exit_timeout_d;
  logic               finish_req_q, finish_req_d;
  logic               timeout_hit;

  sat_counter #(
    .WIDTH(COUNT_W)
  ) u_cycle_cnt (
    .clk  (CLK),
    .clr  (RST),
    .count(cycle_count)
  );

  always_comb begin
    timeout_hit = WD_EN && (cycle_count == LIMIT_M1) &&
                  ((state_q == RUN) || (state_q == DRAIN));
    done_ready  = (state_q == RUN) && !timeout_hit;

    state_d        = state_q;
    drain_cnt_d    = drain_cnt_q;
    exit_code_d    = exit_code_q;
    exit_timeout_d = exit_timeout_q;

    case (state_q)
      RUN: begin
        if (timeout_hit) begin
          state_d        = REQ;
          exit_timeout_d = 1'b1;
          exit_code_d    = TO_CODE;
        end else if (done_valid) begin
          state_d     = DRAIN;
          exit_code_d = done_code;
          drain_cnt_d = DRAIN_RELOAD;
        end
      end
      DRAIN: begin
        if (timeout_hit) begin
          state_d        = REQ;
          exit_timeout_d = 1'b1;
          exit_code_d    = TO_CODE;
        end else if (busy_in) begin
          drain_cnt_d = DRAIN_RELOAD;
        end else if (drain_cnt_q == '0) begin
          state_d = REQ;
        end else begin
          drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
        end
      end
      REQ: begin
        if (finish_ack) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = DONE;
      end
    endcase

    // Registered decode of the next state keeps finish_req aligned with REQ.
    finish_req_d = (state_d == REQ);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= RUN;
      drain_cnt_q    <= '0;
      exit_code_q    <= '0;
      exit_timeout_q <= 1'b0;
      finish_req_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      drain_cnt_q    <= drain_cnt_d;
      exit_code_q    <= exit_code_d;
      exit_timeout_q <= exit_timeout_d;
      finish_req_q   <= finish_req_d;
    end
  end

  assign finish_req   = finish_req_q;
  assign exit_code    = exit_code_q;
  assign exit_timeout = exit_timeout_q;

endmodule

// File: tb/tb_sim_finish_ctrl.sv
// Directed bench for sim_finish_ctrl. Two instances share the stimulus:
// instance 0 uses DRAIN_CYCLES=4 with a 100-cycle watchdog, instance 1 uses
// DRAIN_CYCLES=0 with the watchdog disabled.
module tb_sim_finish_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dv = 1'b0;
  logic [7:0]  dc = '0;
  logic        busy = 1'b0;
  logic        ack = 1'b0;

  logic        ready0, req0, to0;
  logic [7:0]  code0;
  logic [31:0] cnt0;
  logic        ready1, req1, to1;
  logic [7:0]  code1;
  logic [31:0] cnt1;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  sim_finish_ctrl #(
    .COUNT_W(32), .CODE_W(8), .DRAIN_CYCLES(4), .CYCLE_LIMIT(100)
  ) u_dut0 (
    .CLK(clk), .RST(rst), .done_valid(dv), .done_code(dc), .done_ready(ready0),
    .busy_in(busy), .finish_req(req0), .finish_ack(ack), .exit_code(code0),
    .exit_timeout(to0), .cycle_count(cnt0)
  );

  sim_finish_ctrl #(
    .COUNT_W(32), .CODE_W(8), .DRAIN_CYCLES(0), .CYCLE_LIMIT(0)
  ) u_dut1 (
    .CLK(clk), .RST(rst), .done_valid(dv), .done_code(dc), .done_ready(ready1),
    .busy_in(busy), .finish_req(req1), .finish_ack(ack), .exit_code(code1),
    .exit_timeout(to1), .cycle_count(cnt1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 waiting for completion, 1 draining, 2 requesting, 3 finished.
  // Drain is expressed as "DRAIN_CYCLES+1 consecutive idle cycles after acceptance".
  bit          started = 1'b0;
  logic [31:0] m_cnt;
  int          m_phase[2];
  int          m_idle[2];
  logic [7:0]  m_code[2];
  bit          m_to[2];

  function automatic int drain_of(input int i);
    return (i == 0) ? 4 : 0;
  endfunction

  function automatic int limit_of(input int i);
    return (i == 0) ? 100 : 0;
  endfunction

  function automatic bit m_tmo(input int i);
    return (limit_of(i) != 0) && (m_cnt == 32'(limit_of(i) - 1)) && (m_phase[i] <= 1);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      started = 1'b1;
      m_cnt   = '0;
      for (int i = 0; i < 2; i++) begin
        m_phase[i] = 0; m_idle[i] = 0; m_code[i] = '0; m_to[i] = 1'b0;
      end
    end else if (started) begin
      for (int i = 0; i < 2; i++) begin
        if (m_phase[i] <= 1 && m_tmo(i)) begin
          m_phase[i] = 2; m_to[i] = 1'b1; m_code[i] = 8'hFF;
        end else if (m_phase[i] == 0) begin
          if (dv) begin
            m_phase[i] = 1; m_code[i] = dc; m_idle[i] = 0;
          end
        end else if (m_phase[i] == 1) begin
          if (busy) m_idle[i] = 0;
          else begin
            m_idle[i]++;
            if (m_idle[i] == drain_of(i) + 1) m_phase[i] = 2;
          end
        end else if (m_phase[i] == 2) begin
          if (ack) m_phase[i] = 3;
        end
      end
      if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      check("i0_ready", 32'(ready0), 32'(m_phase[0] == 0 && !m_tmo(0)));
      check("i0_req",   32'(req0),   32'(m_phase[0] == 2));
      check("i0_code",  32'(code0),  32'(m_code[0]));
      check("i0_to",    32'(to0),    32'(m_to[0]));
      check("i0_cnt",   cnt0,        m_cnt);
      check("i1_ready", 32'(ready1), 32'(m_phase[1] == 0 && !m_tmo(1)));
      check("i1_req",   32'(req1),   32'(m_phase[1] == 2));
      check("i1_code",  32'(code1),  32'(m_code[1]));
      check("i1_to",    32'(to1),    32'(m_to[1]));
      check("i1_cnt",   cnt1,        m_cnt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; dv = 1'b0; busy = 1'b0; ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic to_cycle(input int n);
    while (cyc < n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // Normal completion, long ack wait, then sticky DONE.
    do_reset();
    check("lit_rst_cnt", cnt0, 32'd0);
    check("lit_rst_req", 32'(req0), 32'd0);
    check("lit_rst_code", 32'(code0), 32'd0);
    to_cycle(10); dv = 1'b1; dc = 8'h05;
    to_cycle(11); dv = 1'b0;
    check("lit_drain_ready", 32'(ready0), 32'd0);
    check("lit_d0_req_off", 32'(req1), 32'd0);
    to_cycle(12);
    check("lit_d0_req_on", 32'(req1), 32'd1);
    to_cycle(15);
    check("lit_req_c15", 32'(req0), 32'd0);
    to_cycle(16);
    check("lit_req_c16", 32'(req0), 32'd1);
    check("lit_code_05", 32'(code0), 32'h05);
    check("lit_to_0", 32'(to0), 32'd0);
    to_cycle(66); ack = 1'b1;
    check("lit_req_held", 32'(req0), 32'd1);
    to_cycle(67); ack = 1'b0;
    check("lit_req_drop", 32'(req0), 32'd0);
    check("lit_done_ready", 32'(ready0), 32'd0);
    dv = 1'b1; dc = 8'h77;
    to_cycle(68); dv = 1'b0;
    check("lit_done_code_kept", 32'(code0), 32'h05);

    // Busy cycles restart the drain window.
    do_reset();
    to_cycle(10); dv = 1'b1; dc = 8'h05;
    to_cycle(11); dv = 1'b0;
    to_cycle(12); busy = 1'b1;
    to_cycle(15); busy = 1'b0;
    to_cycle(19);
    check("lit_busy_req_c19", 32'(req0), 32'd0);
    to_cycle(20);
    check("lit_busy_req_c20", 32'(req0), 32'd1);
    ack = 1'b1;
    to_cycle(21); ack = 1'b0;

    // Watchdog beats a simultaneous completion.
    do_reset();
    to_cycle(99);
    check("lit_wd_ready", 32'(ready0), 32'd0);
    dv = 1'b1; dc = 8'h33;
    to_cycle(100); dv = 1'b0;
    check("lit_wd_req", 32'(req0), 32'd1);
    check("lit_wd_code", 32'(code0), 32'hFF);
    check("lit_wd_to", 32'(to0), 32'd1);
    check("lit_wd_cnt", cnt0, 32'd100);
    to_cycle(102);

    // Reset while requesting, then a normal completion.
    do_reset();
    check("lit_rr_req", 32'(req0), 32'd0);
    check("lit_rr_cnt", cnt0, 32'd0);
    check("lit_rr_to", 32'(to0), 32'd0);
    to_cycle(3); dv = 1'b1; dc = 8'h0A;
    to_cycle(4); dv = 1'b0;
    to_cycle(8);
    check("lit_rr_req_c8", 32'(req0), 32'd0);
    to_cycle(9);
    check("lit_rr_req_c9", 32'(req0), 32'd1);
    check("lit_rr_code", 32'(code0), 32'h0A);
    ack = 1'b1;
    to_cycle(10); ack = 1'b0;

    // Stray acks in RUN and DRAIN do nothing.
    do_reset();
    to_cycle(2); ack = 1'b1;
    to_cycle(3); ack = 1'b0;
    to_cycle(5); dv = 1'b1; dc = 8'h11;
    to_cycle(6); dv = 1'b0;
    to_cycle(7); ack = 1'b1;
    to_cycle(8); ack = 1'b0;
    to_cycle(11);
    check("lit_ack_req_c11", 32'(req0), 32'd1);
    to_cycle(14);
    check("lit_ack_req_c14", 32'(req0), 32'd1);
    to_cycle(15); ack = 1'b1;
    to_cycle(16); ack = 1'b0;
    check("lit_ack_req_c16", 32'(req0), 32'd0);
    check("lit_ack_code", 32'(code0), 32'h11);
    to_cycle(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sim_finish_ctrl.md
Name: sim_finish_ctrl

Overview:
- Design-side counterpart of the simulation top's per-cycle finish poll.
- The top owns the clocks and the reset release, and polls for a finish request every cycle. This block produces that request.
- It collects a completion indication from the portal/test logic and waits until outstanding traffic has drained. It then raises a held finish request with an exit code and waits for the top to acknowledge it.
- A cycle-budget watchdog forces a finish if the design hangs.

Parameters:
- COUNT_W, 32, width of the free-running cycle counter.
- CODE_W, 8, width of the exit code.
- DRAIN_CYCLES, 16, number of consecutive idle cycles required after completion before a finish is requested.
- CYCLE_LIMIT, 0, watchdog limit in cycles; 0 disables the watchdog.

Ports:
- CLK  in  1  sole clock.
- RST  in  1  reset; synchronous, active-high.
- done_valid  in  1  completion offered.
- done_code  in  CODE_W  exit code carried with done_valid.
- done_ready  out  1  completion accepted when done_valid && done_ready.
- busy_in  in  1  traffic still outstanding; blocks drain.
- finish_req  out  1  finish requested; held until acknowledged.
- finish_ack  in  1  top has sampled finish_req.
- exit_code  out  CODE_W  code to report; valid while finish_req=1 and in DONE.
- exit_timeout  out  1  finish was caused by the watchdog.
- cycle_count  out  COUNT_W  cycles since reset release.

Behaviour:
- Reset: synchronous, active-high. On any edge with RST=1, all of the following hold after that edge:
  - state=RUN
  - finish_req=0, exit_code=0, exit_timeout=0, cycle_count=0
  - drain counter=0
  - finish_ack is ignored.
- Reset mid-operation (DRAIN, REQ or DONE) aborts and returns to RUN with the same values.
- cycle_count: increments by 1 every non-reset cycle. It saturates at all-ones and does not wrap.
- States: RUN, DRAIN, REQ, DONE (2-bit enum).
- timeout_hit (combinational) = CYCLE_LIMIT!=0 && cycle_count==CYCLE_LIMIT-1 && state is RUN or DRAIN.
- done_ready = (state==RUN) && !timeout_hit. This is combinational and has no dependency on done_valid.
- RUN:
  - timeout_hit → REQ; exit_timeout←1; exit_code←all-ones.
  - Otherwise, on done_valid && done_ready: exit_code←done_code; drain counter←DRAIN_CYCLES; → DRAIN.
- DRAIN:
  - timeout_hit has priority: → REQ, exit_timeout←1, exit_code←all-ones.
  - Otherwise, if busy_in=1, drain counter←DRAIN_CYCLES.
  - Otherwise, if counter==0 → REQ; else counter−1.
  - done_valid is ignored in this state.
- REQ: finish_req=1. When finish_ack=1 → DONE, and finish_req drops on the following cycle.
- DONE: sticky until RST. finish_req=0. exit_code and exit_timeout are held.
- finish_req is a registered output (decoded from state==REQ).
- finish_ack outside REQ has no effect.
- Latency: if done is accepted on cycle t and busy_in stays 0, DRAIN occupies t+1..t+DRAIN_CYCLES+1 and finish_req is first high on cycle t+DRAIN_CYCLES+2.
- DRAIN_CYCLES=0: DRAIN lasts until the first cycle with busy_in=0, then the block moves to REQ.
- Simultaneous done_valid and timeout_hit in RUN: the watchdog wins and the completion is not accepted (done_ready=0).

Decomposition:
- Shared package sim_finish_pkg holds:
  - the state enum finish_state_t (RUN/DRAIN/REQ/DONE);
  - the constant TIMEOUT_CODE (all-ones, CODE_W);
  - the default DRAIN_CYCLES.
- One natural sub-module: sat_counter (COUNT_W, synchronous clear, saturating increment). It implements cycle_count.
- The drain counter is a simple down-counter in the top module.

Test Plan:
- Reset, then done_valid=1 with done_code=8'h05 on cycle 10, DRAIN_CYCLES=4, busy_in=0 → DRAIN on cycles 11–15; finish_req=1 from cycle 16; exit_code=05; exit_timeout=0.
- Same as above, but busy_in=1 on cycles 12–14 → drain counter reloads each busy cycle; finish_req first high on cycle 20.
- In REQ, hold finish_ack=0 for 50 cycles, then pulse it for 1 cycle → finish_req stays 1 for those 50 cycles, drops the cycle after the ack, and state=DONE. A later done_valid sees done_ready=0.
- CYCLE_LIMIT=100, no done offered → on the edge closing cycle 99 (cycle_count=99) the block enters REQ; finish_req=1 from cycle_count=100; exit_code=FF; exit_timeout=1. Also offer done_valid on the cycle where cycle_count=99 → done_ready=0 and the completion is not accepted.
- Assert RST for 1 cycle while in REQ → next cycle finish_req=0, cycle_count=0, state=RUN. A following done_code=8'h0A completes normally.
- Pulse finish_ack during RUN and DRAIN → no state change; the later REQ still waits for its own ack.
